// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bus: MEM-side capture inputs, pipeline controls and the
// register-file write port. The upstream pipeline uses the master modport;
// the stage uses the slave modport.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  // Pipeline control
  logic              stall;
  logic              flush;
  // MEM-stage slot contents
  logic              mem_valid;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_result;
  logic              mem_is_load;
  logic [2:0]        mem_load_op;
  logic [1:0]        mem_byte_addr;
  logic [DATA_W-1:0] mem_load_data;
  // Register-file write port and status
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              align_err;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output stall, flush, mem_valid, mem_wr_en, mem_wr_addr, mem_result,
           mem_is_load, mem_load_op, mem_byte_addr, mem_load_data,
    input  wr_en, wr_addr, wr_data, align_err, retire_cnt
  );

  modport slave (
    input  stall, flush, mem_valid, mem_wr_en, mem_wr_addr, mem_result,
           mem_is_load, mem_load_op, mem_byte_addr, mem_load_data,
    output wr_en, wr_addr, wr_data, align_err, retire_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with load alignment/extension and retire count.
// Flow control: there is no valid/ready backpressure here. Each edge either
// resets the slot, flushes it to a bubble (flush wins over stall), holds it
// (stall), or captures the MEM inputs. mem_valid marks a real instruction and
// is the only thing that advances retire_cnt. Outputs are combinational from
// the captured slot, so MEM inputs reach the register file one cycle later.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int BIG_ENDIAN = 0,
  parameter int CNT_W      = 32
) (
  input logic          clk,
  input logic          reset,
  mem_wb_stage_if.slave bus
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;

  // Captured WB slot
  logic              s_valid;
  logic              s_wr_en;
  logic [ADDR_W-1:0] s_wr_addr;
  logic [DATA_W-1:0] s_result;
  logic              s_is_load;
  logic [2:0]        s_load_op;
  logic [1:0]        s_byte_addr;
  logic [DATA_W-1:0] s_load_data;
  logic [CNT_W-1:0]  cnt_q;

  // Formatting intermediates
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;
  logic              ld_bad;
  logic              err;

  // Byte k of the memory word; big-endian mirrors the lane order.
  function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] w,
                                          input logic [1:0] k);
    logic [1:0] lane;
    lane = (BIG_ENDIAN != 0) ? ~k : k;
    case (lane)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Slot register and retire counter: reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid     <= 1'b0;
      s_wr_en     <= 1'b0;
      s_wr_addr   <= '0;
      s_result    <= '0;
      s_is_load   <= 1'b0;
      s_load_op   <= 3'b000;
      s_byte_addr <= 2'b00;
      s_load_data <= '0;
      cnt_q       <= '0;
    end else if (bus.flush) begin
      s_valid     <= 1'b0;
      s_wr_en     <= 1'b0;
      s_wr_addr   <= '0;
      s_result    <= '0;
      s_is_load   <= 1'b0;
      s_load_op   <= 3'b000;
      s_byte_addr <= 2'b00;
      s_load_data <= '0;
    end else if (!bus.stall) begin
      s_valid     <= bus.mem_valid;
      s_wr_en     <= bus.mem_wr_en;
      s_wr_addr   <= bus.mem_wr_addr;
      s_result    <= bus.mem_result;
      s_is_load   <= bus.mem_is_load;
      s_load_op   <= bus.mem_load_op;
      s_byte_addr <= bus.mem_byte_addr;
      s_load_data <= bus.mem_load_data;
      if (bus.mem_valid) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Load alignment/extension and misalignment detection from the slot.
  always_comb begin
    ld_byte = byte_sel(s_load_data, s_byte_addr);
    if (BIG_ENDIAN != 0) begin
      ld_half = {byte_sel(s_load_data, {s_byte_addr[1], 1'b0}),
                 byte_sel(s_load_data, {s_byte_addr[1], 1'b1})};
    end else begin
      ld_half = {byte_sel(s_load_data, {s_byte_addr[1], 1'b1}),
                 byte_sel(s_load_data, {s_byte_addr[1], 1'b0})};
    end
    ld_val = s_load_data;
    ld_bad = 1'b0;
    case (s_load_op)
      OP_LB:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: ld_val = {24'h0, ld_byte};
      OP_LH: begin
        ld_val = {{16{ld_half[15]}}, ld_half};
        ld_bad = s_byte_addr[0];
      end
      OP_LHU: begin
        ld_val = {16'h0, ld_half};
        ld_bad = s_byte_addr[0];
      end
      OP_LW:  ld_bad = |s_byte_addr;
      default: ld_bad = 1'b1;
    endcase
    err = s_valid & s_is_load & ld_bad;
  end

  // Register-file write port; a bubble slot drives zeros.
  always_comb begin
    bus.align_err  = err;
    bus.wr_en      = s_valid & s_wr_en & ~err & (s_wr_addr != '0);
    bus.wr_addr    = s_valid ? s_wr_addr : '0;
    bus.wr_data    = '0;
    if (s_valid) begin
      bus.wr_data = s_is_load ? ld_val : s_result;
    end
    bus.retire_cnt = cnt_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a little-endian 32-bit-counter instance and a
// big-endian 4-bit-counter instance share one stimulus stream and are checked
// each cycle against an arithmetic reference model.
module tb_mem_wb_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_result;
  logic        mem_is_load;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_byte_addr;
  logic [31:0] mem_load_data;

  mem_wb_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) if_le ();
  mem_wb_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  if_be ();

  assign if_le.stall = stall;             assign if_be.stall = stall;
  assign if_le.flush = flush;             assign if_be.flush = flush;
  assign if_le.mem_valid = mem_valid;     assign if_be.mem_valid = mem_valid;
  assign if_le.mem_wr_en = mem_wr_en;     assign if_be.mem_wr_en = mem_wr_en;
  assign if_le.mem_wr_addr = mem_wr_addr; assign if_be.mem_wr_addr = mem_wr_addr;
  assign if_le.mem_result = mem_result;   assign if_be.mem_result = mem_result;
  assign if_le.mem_is_load = mem_is_load; assign if_be.mem_is_load = mem_is_load;
  assign if_le.mem_load_op = mem_load_op; assign if_be.mem_load_op = mem_load_op;
  assign if_le.mem_byte_addr = mem_byte_addr;
  assign if_be.mem_byte_addr = mem_byte_addr;
  assign if_le.mem_load_data = mem_load_data;
  assign if_be.mem_load_data = mem_load_data;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .BIG_ENDIAN(0), .CNT_W(32)) u_le (
    .clk(clk), .reset(reset), .bus(if_le)
  );
  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .BIG_ENDIAN(1), .CNT_W(4)) u_be (
    .clk(clk), .reset(reset), .bus(if_be)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected vector: {wr_en, wr_addr, data_le, data_be, align_err, cnt_le, cnt_be}
  localparam int EXP_W = 1 + 5 + 32 + 32 + 1 + 32 + 4;
  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    bit          valid;
    bit          we;
    bit          is_load;
    int unsigned addr;
    int unsigned result;
    int unsigned data;
    int unsigned op;
    int unsigned ba;
  } slot_t;

  slot_t          m_slot;
  longint unsigned cnt_le;
  int unsigned    cnt_be;

  function automatic int unsigned byte_at(bit be, int unsigned data, int unsigned k);
    int unsigned pos;
    pos = be ? (3 - k) : k;
    return (data >> (8 * pos)) & 32'hFF;
  endfunction

  function automatic bit load_bad(int unsigned op, int unsigned ba);
    if (op == 2 || op == 3) return (ba % 2) != 0;
    if (op == 4) return ba != 0;
    return op > 4;
  endfunction

  function automatic int unsigned load_fmt(bit be, int unsigned op,
                                           int unsigned ba, int unsigned data);
    int unsigned b, h, lo;
    lo = ba & 2;
    b  = byte_at(be, data, ba);
    h  = be ? byte_at(be, data, lo) * 256 + byte_at(be, data, lo + 1)
            : byte_at(be, data, lo + 1) * 256 + byte_at(be, data, lo);
    case (op)
      0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      1: return b;
      2: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3: return h;
      default: return data;
    endcase
  endfunction

  // Apply one edge's worth of rules to the model and queue the outputs.
  task automatic model_step();
    bit          e_err, e_en;
    int unsigned e_addr, d_le, d_be;
    if (reset) begin
      m_slot = '{default: 0};
      cnt_le = 0;
      cnt_be = 0;
    end else if (flush) begin
      m_slot.valid = 0;
    end else if (!stall) begin
      m_slot = '{mem_valid, mem_wr_en, mem_is_load, mem_wr_addr, mem_result,
                 mem_load_data, mem_load_op, mem_byte_addr};
      if (mem_valid) begin
        cnt_le = (cnt_le + 1) % 64'h1_0000_0000;
        cnt_be = (cnt_be + 1) % 16;
      end
    end
    e_err = 0; e_en = 0; e_addr = 0; d_le = 0; d_be = 0;
    if (m_slot.valid) begin
      e_err  = m_slot.is_load && load_bad(m_slot.op, m_slot.ba);
      e_en   = m_slot.we && !e_err && m_slot.addr != 0;
      e_addr = m_slot.addr;
      d_le   = m_slot.is_load ? load_fmt(0, m_slot.op, m_slot.ba, m_slot.data) : m_slot.result;
      d_be   = m_slot.is_load ? load_fmt(1, m_slot.op, m_slot.ba, m_slot.data) : m_slot.result;
    end
    exp_q.push_back({e_en, 5'(e_addr), 32'(d_le), 32'(d_be), e_err,
                     32'(cnt_le), 4'(cnt_be)});
  endtask

  task automatic compare();
    logic [EXP_W-1:0] e;
    logic        e_en, e_err;
    logic [4:0]  e_addr;
    logic [31:0] e_dle, e_dbe, e_cle;
    logic [3:0]  e_cbe;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    {e_en, e_addr, e_dle, e_dbe, e_err, e_cle, e_cbe} = e;
    check_val("le_wr_en", if_le.wr_en, e_en);
    check_val("be_wr_en", if_be.wr_en, e_en);
    check_val("le_wr_addr", if_le.wr_addr, e_addr);
    check_val("be_wr_addr", if_be.wr_addr, e_addr);
    check_val("le_align_err", if_le.align_err, e_err);
    check_val("be_align_err", if_be.align_err, e_err);
    if (!e_err) begin
      check_val("le_wr_data", if_le.wr_data, e_dle);
      check_val("be_wr_data", if_be.wr_data, e_dbe);
    end
    check_val("le_retire_cnt", if_le.retire_cnt, e_cle);
    check_val("be_retire_cnt", if_be.retire_cnt, e_cbe);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0;
    mem_valid = 0; mem_wr_en = 0; mem_wr_addr = '0; mem_result = '0;
    mem_is_load = 0; mem_load_op = '0; mem_byte_addr = '0; mem_load_data = '0;
  endtask

  task automatic set_alu(input logic [4:0] addr, input logic [31:0] res);
    idle();
    mem_valid = 1; mem_wr_en = 1; mem_wr_addr = addr; mem_result = res;
  endtask

  task automatic set_load(input logic [2:0] op, input logic [1:0] ba,
                          input logic [31:0] data, input logic [4:0] addr);
    idle();
    mem_valid = 1; mem_wr_en = 1; mem_wr_addr = addr; mem_is_load = 1;
    mem_load_op = op; mem_byte_addr = ba; mem_load_data = data;
    mem_result = $urandom;
  endtask

  task automatic set_random();
    reset         = ($urandom_range(0, 99) == 0);
    flush         = ($urandom_range(0, 9) == 0);
    stall         = ($urandom_range(0, 4) == 0);
    mem_valid     = ($urandom_range(0, 9) < 8);
    mem_wr_en     = ($urandom_range(0, 9) < 8);
    mem_wr_addr   = 5'($urandom_range(0, 31));
    mem_result    = $urandom;
    mem_is_load   = $urandom_range(0, 1) == 1;
    mem_load_op   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4))
                                               : 3'($urandom_range(5, 7));
    mem_byte_addr = 2'($urandom_range(0, 3));
    mem_load_data = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held_cnt;
    m_slot = '{default: 0};
    cnt_le = 0;
    cnt_be = 0;
    idle();

    reset = 1;
    repeat (3) cycle();
    reset = 0;
    check_val("rst_wr_en", if_le.wr_en, 0);
    check_val("rst_wr_data", if_le.wr_data, 0);
    check_val("rst_retire_cnt", if_le.retire_cnt, 0);
    check_val("rst_align_err", if_le.align_err, 0);

    set_alu(5'd5, 32'h1234_5678); cycle();
    check_val("alu_wr_en", if_le.wr_en, 1);
    check_val("alu_wr_addr", if_le.wr_addr, 5);
    check_val("alu_wr_data", if_le.wr_data, 32'h1234_5678);
    check_val("alu_retire_cnt", if_le.retire_cnt, 1);

    set_load(3'b000, 2'd3, 32'h80FF_7F01, 5'd7); cycle();
    check_val("lb_b3", if_le.wr_data, 32'hFFFF_FF80);
    set_load(3'b001, 2'd3, 32'h80FF_7F01, 5'd7); cycle();
    check_val("lbu_b3", if_le.wr_data, 32'h0000_0080);
    set_load(3'b010, 2'd2, 32'h80FF_7F01, 5'd7); cycle();
    check_val("lh_a2", if_le.wr_data, 32'hFFFF_80FF);
    set_load(3'b010, 2'd1, 32'h80FF_7F01, 5'd7); cycle();
    check_val("lh_a1_err", if_le.align_err, 1);
    check_val("lh_a1_wr_en", if_le.wr_en, 0);

    set_alu(5'd0, 32'h0000_DEAD); cycle();
    check_val("r0_wr_en", if_le.wr_en, 0);

    set_alu(5'd9, 32'h0000_CAFE); cycle();
    held_cnt = if_le.retire_cnt;
    set_alu(5'd11, 32'h1111_2222);
    stall = 1;
    repeat (2) cycle();
    check_val("stall_wr_data", if_le.wr_data, 32'h0000_CAFE);
    check_val("stall_wr_addr", if_le.wr_addr, 9);
    check_val("stall_cnt", if_le.retire_cnt, held_cnt);

    flush = 1; cycle();
    check_val("flush_wr_en", if_le.wr_en, 0);
    check_val("flush_wr_addr", if_le.wr_addr, 0);
    check_val("flush_cnt", if_le.retire_cnt, held_cnt);

    set_load(3'b001, 2'd0, 32'hAB00_0000, 5'd3); cycle();
    check_val("be_lbu_a0", if_be.wr_data, 32'h0000_00AB);

    idle(); reset = 1; cycle();
    set_alu(5'd1, 32'h5);
    repeat (15) cycle();
    check_val("be_cnt_max", if_be.retire_cnt, 4'hF);
    cycle();
    check_val("be_cnt_wrap", if_be.retire_cnt, 4'h0);

    repeat (400) begin
      set_random();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
